// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM arbiter: FSM states, slot owners,
// controller strobe bundle and the timing defaults.
package sdram_arb_pkg;

  localparam int SLOT_DEFAULT             = 14;
  localparam int REFRESH_INTERVAL_DEFAULT = 390;
  localparam int STARVE_LIMIT             = 2;

  typedef enum logic [1:0] {
    ST_WAITRDY,
    ST_IDLE,
    ST_SLOT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_REF,
    OWN_VID,
    OWN_CPU
  } owner_e;

  typedef struct packed {
    logic refresh;
    logic write;
    logic read;
  } strobe_t;

  // Strobe pattern for a slot owned by `own`; `we` only matters for the CPU.
  function automatic strobe_t strobe_for(owner_e own, logic we);
    strobe_t s;
    s = '0;
    case (own)
      OWN_REF: s.refresh = 1'b1;
      OWN_VID: s.read    = 1'b1;
      OWN_CPU: if (we) s.write = 1'b1; else s.read = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and controller-side bus of the SDRAM arbiter. The arbiter uses
// the slave modport; whoever drives requests and models the controller uses master.
interface sdram_arbiter_if;
  logic        vidReq;
  logic [23:0] vidA;
  logic [15:0] vidQ;
  logic        vidAck;

  logic        cpuReq;
  logic        cpuWe;
  logic [23:0] cpuA;
  logic [15:0] cpuD;
  logic [15:0] cpuQ;
  logic        cpuAck;

  logic        memRefresh;
  logic        memWrite;
  logic        memRead;
  logic [23:0] memA;
  logic [15:0] memD;
  logic [15:0] memQ;

  modport slave (
    input  vidReq, vidA, cpuReq, cpuWe, cpuA, cpuD, memQ,
    output vidQ, vidAck, cpuQ, cpuAck, memRefresh, memWrite, memRead, memA, memD
  );

  modport master (
    output vidReq, vidA, cpuReq, cpuWe, cpuA, cpuD, memQ,
    input  vidQ, vidAck, cpuQ, cpuAck, memRefresh, memWrite, memRead, memA, memD
  );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with a 2-bit saturating count of owed refreshes.
// Only instantiated when SDRAM_ARB_REFRESH_EN is defined.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic dec_i,
  output logic pending_o
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  logic          expire;
  logic          take;

  assign expire = (timer_q == TW'(INTERVAL - 1));
  assign take   = dec_i && (pend_q != 2'd0);

  always_comb begin
    timer_d = expire ? '0 : timer_q + 1'b1;
    pend_d  = pend_q;
    // An expiry and a grant in the same cycle cancel out.
    case ({expire, take})
      2'b10:   pend_d = (pend_q == 2'd3) ? pend_q : pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      pend_q  <= 2'd0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign pending_o = (pend_q != 2'd0);

endmodule

// File: rtl/sdram_arbiter.sv
// Time-slotted arbiter sharing one SDRAM controller between video, CPU and
// refresh. Define SDRAM_ARB_REFRESH_EN to include the internal refresh timer.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int SLOT             = SLOT_DEFAULT,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ready,
  sdram_arbiter_if.slave bus
);

  localparam int CW = $clog2(SLOT);

  if (SLOT < 12 || REFRESH_INTERVAL < 2) begin : g_bad_cfg
    $error("sdram_arbiter: SLOT must be >= 12 and REFRESH_INTERVAL >= 2");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_e        owner_q, owner_d;
  owner_e        grant;
  logic          we_q, we_d;
  logic [1:0]    starve_q, starve_d;
  strobe_t       strobe_q, strobe_d;
  logic [23:0]   memA_q, memA_d;
  logic [15:0]   memD_q, memD_d;
  logic [15:0]   vidQ_q, vidQ_d, cpuQ_q, cpuQ_d;
  logic          vidAck_q, vidAck_d, cpuAck_q, cpuAck_d;
  logic          ref_pend;

`ifdef SDRAM_ARB_REFRESH_EN
  logic ref_dec;
  assign ref_dec = (grant == OWN_REF);

  sdram_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh (
    .clock     (clock),
    .reset     (reset),
    .dec_i     (ref_dec),
    .pending_o (ref_pend)
  );
`else
  assign ref_pend = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    starve_d = starve_q;
    strobe_d = strobe_q;
    memA_d   = memA_q;
    memD_d   = memD_q;
    vidQ_d   = vidQ_q;
    cpuQ_d   = cpuQ_q;
    vidAck_d = 1'b0;
    cpuAck_d = 1'b0;
    grant    = OWN_NONE;

    case (state_q)
      ST_WAITRDY: if (ready) state_d = ST_IDLE;

      ST_IDLE: begin
        if (!ready) begin
          state_d = ST_WAITRDY;
        end else begin
          if (ref_pend)
            grant = OWN_REF;
          else if (bus.cpuReq && (!bus.vidReq || starve_q >= 2'(STARVE_LIMIT)))
            grant = OWN_CPU;
          else if (bus.vidReq)
            grant = OWN_VID;

          if (grant != OWN_NONE) begin
            state_d  = ST_SLOT;
            cnt_d    = '0;
            owner_d  = grant;
            we_d     = (grant == OWN_CPU) && bus.cpuWe;
            strobe_d = strobe_for(grant, bus.cpuWe);
            memA_d   = '0;
            memD_d   = '0;
            case (grant)
              OWN_VID: begin
                memA_d   = bus.vidA;
                starve_d = !bus.cpuReq ? 2'd0 :
                           (starve_q >= 2'(STARVE_LIMIT)) ? starve_q : starve_q + 2'd1;
              end
              OWN_CPU: begin
                memA_d   = bus.cpuA;
                memD_d   = bus.cpuD;
                starve_d = 2'd0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_SLOT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) strobe_d = '0;
        // Ack and read data are registered, so they are loaded on the edge
        // that enters s=SLOT-1; controller data is long settled by then.
        if (cnt_q == CW'(SLOT - 2)) begin
          case (owner_q)
            OWN_VID: begin
              vidAck_d = 1'b1;
              vidQ_d   = bus.memQ;
            end
            OWN_CPU: begin
              cpuAck_d = 1'b1;
              if (!we_q) cpuQ_d = bus.memQ;
            end
            default: ;
          endcase
        end
        if (cnt_q == CW'(SLOT - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end

      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ready ? ST_IDLE : ST_WAITRDY;
      end

      default: state_d = ST_WAITRDY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_WAITRDY;
      cnt_q    <= '0;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      starve_q <= 2'd0;
      strobe_q <= '0;
      memA_q   <= '0;
      memD_q   <= '0;
      vidQ_q   <= '0;
      cpuQ_q   <= '0;
      vidAck_q <= 1'b0;
      cpuAck_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
      strobe_q <= strobe_d;
      memA_q   <= memA_d;
      memD_q   <= memD_d;
      vidQ_q   <= vidQ_d;
      cpuQ_q   <= cpuQ_d;
      vidAck_q <= vidAck_d;
      cpuAck_q <= cpuAck_d;
    end
  end

  assign bus.memRefresh = strobe_q.refresh;
  assign bus.memWrite   = strobe_q.write;
  assign bus.memRead    = strobe_q.read;
  assign bus.memA       = memA_q;
  assign bus.memD       = memD_q;
  assign bus.vidQ       = vidQ_q;
  assign bus.cpuQ       = cpuQ_q;
  assign bus.vidAck     = vidAck_q;
  assign bus.cpuAck     = cpuAck_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with an ack scoreboard and a small
// controller model that returns memA[15:0]^16'h5A5A during s=9..13.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  own;
    logic [15:0] data;
  } exp_t;

  logic clock, reset, ready;
  sdram_arbiter_if bus ();

  sdram_arbiter #(.SLOT(14), .REFRESH_INTERVAL(40)) dut (
    .clock (clock),
    .reset (reset),
    .ready (ready),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic grant_log[$];
  int   s_tb = 100;
  logic prev_any = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.memQ = (s_tb >= 9 && s_tb <= 13) ? (bus.memA[15:0] ^ 16'h5A5A) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Slot tracker, strobe sanity and ack scoreboard.
  always @(negedge clock) begin
    logic any_s;
    exp_t e;
    any_s = bus.memRefresh | bus.memWrite | bus.memRead;
    if (any_s && !prev_any) begin
      s_tb = 0;
      grant_log.push_back(bus.memRefresh);
    end else if (s_tb < 100) begin
      s_tb++;
    end
    prev_any = any_s;
    if (any_s) chk("strobe_onehot", $countones({bus.memRefresh, bus.memWrite, bus.memRead}), 1);
    if (bus.vidAck || bus.cpuAck) chk("ack_exclusive", bus.vidAck & bus.cpuAck, 0);
    if (bus.vidAck) begin
      chk("vid_ack_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vid_ack_owner", e.own, OWN_VID);
        chk("vidQ", bus.vidQ, e.data);
      end
    end
    if (bus.cpuAck) begin
      chk("cpu_ack_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_ack_owner", e.own, OWN_CPU);
        chk("cpuQ", bus.cpuQ, e.data);
      end
    end
  end

  initial begin
    int   n;
    int   acks;
    logic seen;

    reset = 1'b1; ready = 1'b0;
    bus.vidReq = 1'b0; bus.vidA = '0;
    bus.cpuReq = 1'b0; bus.cpuWe = 1'b0; bus.cpuA = '0; bus.cpuD = '0;
    tick(); tick();

    // Reset values
    chk("rst_strobes", {bus.memRefresh, bus.memWrite, bus.memRead}, 0);
    chk("rst_acks", {bus.vidAck, bus.cpuAck}, 0);
    chk("rst_vidQ", bus.vidQ, 0);
    chk("rst_cpuQ", bus.cpuQ, 0);
    chk("rst_memA", bus.memA, 0);
    chk("rst_memD", bus.memD, 0);

    // Single CPU write
    reset = 1'b0; ready = 1'b1;
    tick();
    bus.cpuA = 24'h012345; bus.cpuD = 16'hBEEF; bus.cpuWe = 1'b1; bus.cpuReq = 1'b1;
    exp_q.push_back('{own: OWN_CPU, data: 16'h0000});
    n = 0;
    do begin tick(); n++; end while (!bus.memWrite && n < 10);
    chk("wr_grant_latency", n, 1);
    for (int k = 0; k <= 13; k++) begin
      chk($sformatf("wr_memWrite_s%0d", k), bus.memWrite, (k < 2));
      chk($sformatf("wr_other_strobes_s%0d", k), {bus.memRefresh, bus.memRead}, 0);
      chk($sformatf("wr_memA_s%0d", k), bus.memA, 24'h012345);
      chk($sformatf("wr_memD_s%0d", k), bus.memD, 16'hBEEF);
      chk($sformatf("wr_cpuAck_s%0d", k), bus.cpuAck, (k == 13));
      if (k == 13) bus.cpuReq = 1'b0;
      else tick();
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.memWrite || bus.memRead) seen = 1'b1;
    end
    chk("wr_no_regrant", seen, 0);

    // Video read returning A55A
    bus.vidA = 24'h00FF00;
    exp_q.push_back('{own: OWN_VID, data: 16'hA55A});
    bus.vidReq = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.memRead && n < 40);
    chk("vid_grant_seen", bus.memRead, 1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("vid_ack_s%0d", k), bus.vidAck, (k == 13));
    end
    chk("vid_data_with_ack", bus.vidQ, 16'hA55A);
    bus.vidReq = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("vidQ_hold", bus.vidQ, 16'hA55A);

    // Both held: VID, VID, CPU, VID, VID, CPU
    bus.vidA = 24'h101234; bus.cpuA = 24'h205678; bus.cpuWe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{own: OWN_VID, data: 16'h486E});
      exp_q.push_back('{own: OWN_VID, data: 16'h486E});
      exp_q.push_back('{own: OWN_CPU, data: 16'h0C22});
    end
    bus.vidReq = 1'b1; bus.cpuReq = 1'b1;
    acks = 0; n = 0;
    while (acks < 6 && n < 400) begin
      tick(); n++;
      if (bus.vidAck || bus.cpuAck) acks++;
    end
    bus.vidReq = 1'b0; bus.cpuReq = 1'b0;
    chk("order_ack_count", acks, 6);
    for (int k = 0; k < 4; k++) tick();
    chk("order_sb_empty", exp_q.size(), 0);

    // Reset at s=5 of a CPU read, then ready held low
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    bus.cpuA = 24'h00ABCD; bus.cpuWe = 1'b0; bus.cpuReq = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.memRead && n < 40);
    chk("rd_grant_seen", bus.memRead, 1);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_strobes", {bus.memRefresh, bus.memWrite, bus.memRead}, 0);
    chk("rst_mid_memA", bus.memA, 0);
    reset = 1'b0; ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.memRefresh || bus.memWrite || bus.memRead || bus.cpuAck) seen = 1'b1;
    end
    chk("notready_quiet", seen, 0);
    exp_q.push_back('{own: OWN_CPU, data: 16'hF197});
    ready = 1'b1;
    tick();
    chk("ready_idle_no_strobe", {bus.memRefresh, bus.memWrite, bus.memRead}, 0);
    tick();
    chk("ready_grant_next", bus.memRead, 1);
    n = 0;
    do begin tick(); n++; end while (!bus.cpuAck && n < 20);
    chk("ready_read_ack_latency", n, 13);
    bus.cpuReq = 1'b0;
    for (int k = 0; k < 4; k++) tick();

`ifdef SDRAM_ARB_REFRESH_EN
    // Two expiries while not ready: two back-to-back refresh slots first
    reset = 1'b1; ready = 1'b0; tick(); tick(); reset = 1'b0;
    bus.vidA = 24'h101234; bus.vidReq = 1'b1;
    for (int k = 0; k < 82; k++) tick();
    grant_log.delete();
    exp_q.push_back('{own: OWN_VID, data: 16'h486E});
    ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.vidAck && n < 100);
    bus.vidReq = 1'b0;
    chk("ref_grant_count", grant_log.size() >= 3, 1);
    if (grant_log.size() >= 3) begin
      chk("ref_first", grant_log[0], 1);
      chk("ref_second", grant_log[1], 1);
      chk("ref_then_vid", grant_log[2], 0);
    end
    for (int k = 0; k < 4; k++) tick();
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
